// File: rtl/day1_seq_pkg.sv
// Shared AoC package: dial rotation direction, sequencer state encoding,
// and the instruction record that travels through the instruction FIFO.
package day1_seq_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } rotDir_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

    // One buffered instruction; 'last' rides along so the sequencer knows
    // when the final instruction of the job leaves the FIFO.
    typedef struct packed {
        logic        last;
        rotDir_t     dir;
        logic [31:0] clicks;
    } instr_t;

    localparam int          INSTR_W   = $bits(instr_t);
    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/day1_seq_if.sv
// Bundle of the sequencer's handshake and datapath signals.
//   slave  : view of the sequencer (day1_seq)
//   master : view of the environment (instruction source, dial datapath,
//            result consumer)
// Signals: start; in_valid/in_ready/in_dir/in_clicks/in_last (instruction
// stream); dp_clear/dp_step/dp_direction/dp_clicks/dp_password (datapath);
// busy, result_valid/result_ready/result, instr_count (status and result).
interface day1_seq_if;

    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    day1_seq_pkg::rotDir_t    in_dir;
    logic [31:0]              in_clicks;
    logic                     in_last;
    logic                     dp_clear;
    logic                     dp_step;
    day1_seq_pkg::rotDir_t    dp_direction;
    logic [31:0]              dp_clicks;
    logic [31:0]              dp_password;
    logic                     busy;
    logic                     result_valid;
    logic                     result_ready;
    logic [31:0]              result;
    logic [31:0]              instr_count;

    modport slave (
        input  start, in_valid, in_dir, in_clicks, in_last, dp_password, result_ready,
        output in_ready, dp_clear, dp_step, dp_direction, dp_clicks,
               busy, result_valid, result, instr_count
    );

    modport master (
        output start, in_valid, in_dir, in_clicks, in_last, dp_password, result_ready,
        input  in_ready, dp_clear, dp_step, dp_direction, dp_clicks,
               busy, result_valid, result, instr_count
    );

endinterface

// File: rtl/day1_seq_fifo.sv
// sync_fifo: small synchronous FIFO with a combinational head read.
// Ports: clock, reset (sync, active-high), clear (sync flush), push/din,
// pop/dout (dout is the current head), full, empty.
// A push arriving together with clear is kept: the FIFO restarts holding
// just that entry, so an instruction accepted during the clear cycle is
// not lost. Pop is ignored while clearing.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] slot_data [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_idx;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && (clear || !full);
    assign do_pop  = pop && !empty && !clear;
    assign wr_idx  = clear ? '0 : wr_ptr_reg;
    assign dout    = slot_data[rd_ptr_reg];

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [WIDTH-1:0] slot_reg;
        always_ff @(posedge clock) begin
            if (do_push && (wr_idx == AW'(gi))) begin
                slot_reg <= din;
            end
        end
        assign slot_data[gi] = slot_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= do_push ? AW'(1) : '0;
            rd_ptr_reg <= '0;
            count_reg  <= do_push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/day1_seq.sv
// day1_seq: job sequencer for the AoC day-1 dial datapath. Buffers rotation
// instructions, issues them one per cycle to the datapath (dp_step), and
// captures the final password once the last instruction has settled.
// Ports: clock, reset (sync, active-high), bus (day1_seq_if.slave).
module day1_seq
    import day1_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DP_LATENCY = 1
) (
    input logic       clock,
    input logic       reset,
    day1_seq_if.slave bus
);

    localparam int DW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

    seq_state_t    state_reg;
    logic          last_accepted_reg;
    logic          dp_clear_reg;
    logic          dp_step_reg;
    rotDir_t       dp_dir_reg;
    logic [31:0]   dp_clicks_reg;
    logic          issue_last_reg;
    logic          busy_reg;
    logic          result_valid_reg;
    logic [31:0]   result_reg;
    logic [31:0]   instr_count_reg;
    logic [DW-1:0] drain_cnt_reg;

    instr_t fifo_din;
    instr_t fifo_head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_clear;
    logic   in_ready;
    logic   push;
    logic   pop;
    logic   start_ok;

    assign fifo_din   = '{last: bus.in_last, dir: bus.in_dir, clicks: bus.in_clicks};
    assign fifo_clear = (state_reg == CLEAR);
    // No bypass: full blocks acceptance even when a pop happens this cycle.
    assign in_ready   = ((state_reg == CLEAR) || (state_reg == RUN))
                        && !fifo_full && !last_accepted_reg;
    assign push       = bus.in_valid && in_ready;
    assign pop        = (state_reg == RUN) && !fifo_empty;
    assign start_ok   = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (fifo_clear),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            last_accepted_reg <= 1'b0;
            dp_clear_reg      <= 1'b0;
            dp_step_reg       <= 1'b0;
            dp_dir_reg        <= LEFT;
            dp_clicks_reg     <= '0;
            issue_last_reg    <= 1'b0;
            busy_reg          <= 1'b0;
            result_valid_reg  <= 1'b0;
            result_reg        <= '0;
            instr_count_reg   <= '0;
            drain_cnt_reg     <= '0;
        end else begin
            dp_clear_reg   <= 1'b0;
            dp_step_reg    <= pop;
            issue_last_reg <= pop && fifo_head.last;

            // Issue registers hold their value across bubbles.
            if (pop) begin
                dp_dir_reg    <= fifo_head.dir;
                dp_clicks_reg <= fifo_head.clicks;
                if (instr_count_reg != COUNT_MAX) begin
                    instr_count_reg <= instr_count_reg + 32'd1;
                end
            end

            if (push && bus.in_last) begin
                last_accepted_reg <= 1'b1;
            end

            case (state_reg)
                CLEAR: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    // Leave once the final instruction is on the datapath.
                    if (dp_step_reg && issue_last_reg) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= DW'(DP_LATENCY - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        state_reg        <= DONE;
                        result_reg       <= bus.dp_password;
                        result_valid_reg <= 1'b1;
                        busy_reg         <= 1'b0;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - DW'(1);
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state_reg        <= IDLE;
                        result_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // A new job overrides everything above; only reachable from
            // IDLE or DONE, where no push or pop can be in flight.
            if (start_ok) begin
                state_reg         <= CLEAR;
                dp_clear_reg      <= 1'b1;
                busy_reg          <= 1'b1;
                result_valid_reg  <= 1'b0;
                last_accepted_reg <= 1'b0;
                instr_count_reg   <= '0;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.dp_clear     = dp_clear_reg;
    assign bus.dp_step      = dp_step_reg;
    assign bus.dp_direction = dp_dir_reg;
    assign bus.dp_clicks    = dp_clicks_reg;
    assign bus.busy         = busy_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.result       = result_reg;
    assign bus.instr_count  = instr_count_reg;

endmodule

// File: tb/tb_day1_seq.sv
// Self-checking bench for day1_seq: a dial datapath stands in for day1,
// and each job's password is predicted from the instruction list alone.
module tb_day1_seq;
    import day1_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    day1_seq_if bus();

    day1_seq #(
        .FIFO_DEPTH (DEPTH),
        .DP_LATENCY (LAT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- dial datapath stand-in ----------------
    int unsigned dial = 50;
    logic [31:0] pw   = '0;

    function automatic int unsigned next_dial(input int unsigned d, input rotDir_t dir,
                                              input logic [31:0] c);
        int unsigned m;
        m = c % 100;
        return (dir == RIGHT) ? (d + m) % 100 : (d + 100 - m) % 100;
    endfunction

    always @(posedge clock) begin
        if (reset || bus.dp_clear) begin
            dial <= 50;
            pw   <= '0;
        end else if (bus.dp_step) begin
            dial <= next_dial(dial, bus.dp_direction, bus.dp_clicks);
            if (next_dial(dial, bus.dp_direction, bus.dp_clicks) == 0) pw <= pw + 32'd1;
        end
    end
    assign bus.dp_password = pw;

    // ---------------- issue monitor ----------------
    int         cyc            = 0;
    int         steps_seen     = 0;
    int         first_step_cyc = 0;
    int         last_step_cyc  = 0;
    int         accept_cyc     = 0;
    bit         overlap_seen   = 1'b0;
    logic [32:0] issued[$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.dp_clear && bus.dp_step) overlap_seen <= 1'b1;
        if (bus.dp_clear) begin
            steps_seen <= 0;
            issued.delete();
        end else if (bus.dp_step) begin
            issued.push_back({bus.dp_direction == RIGHT, bus.dp_clicks});
            if (steps_seen == 0) first_step_cyc <= cyc;
            last_step_cyc <= cyc;
            steps_seen    <= steps_seen + 1;
        end
    end

    // ---------------- job list and reference model ----------------
    bit          jd[$];   // 1 = RIGHT
    logic [31:0] jc[$];

    function automatic int unsigned ref_password();
        longint      pos  = 50;
        int unsigned hits = 0;
        for (int i = 0; i < jc.size(); i++) begin
            longint c = longint'(jc[i]);
            pos = jd[i] ? pos + c : pos - c;
            pos = ((pos % 100) + 100) % 100;
            if (pos == 0) hits++;
        end
        return hits;
    endfunction

    task automatic load_aoc();
        int c[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
        bit d[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
        jd.delete();
        jc.delete();
        for (int i = 0; i < 10; i++) begin
            jd.push_back(d[i]);
            jc.push_back(32'(c[i]));
        end
    endtask

    task automatic make_random_job(input int n);
        jd.delete();
        jc.delete();
        for (int i = 0; i < n; i++) begin
            jd.push_back(1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0:       jc.push_back(32'd0);
                1:       jc.push_back(32'($urandom_range(1, 99)));
                2:       jc.push_back(32'($urandom_range(100, 1000)));
                default: jc.push_back($urandom);
            endcase
        end
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic stream(input int gap, input int abort_at, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < jc.size(); i++) begin
            bit acc;
            int waited;
            bus.in_valid  = 1'b1;
            bus.in_dir    = jd[i] ? RIGHT : LEFT;
            bus.in_clicks = jc[i];
            bus.in_last   = (i == jc.size() - 1);
            acc    = 1'b0;
            waited = 0;
            while (!acc) begin
                @(negedge clock);
                acc = bus.in_ready;
                @(posedge clock); #1;
                if (acc && i == 0) accept_cyc = cyc - 1;
                if (abort_at >= 0 && steps_seen >= abort_at) begin
                    aborted      = 1'b1;
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'b0;
                    return;
                end
                waited++;
                if (!acc && waited > 200) begin
                    check_eq("accept_timeout", 64'd0, 64'd1);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic wait_result(output logic [31:0] r, output int rv_cyc);
        int n = 0;
        while (!bus.result_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("result_valid_seen", 64'(bus.result_valid), 64'd1);
        r      = bus.result;
        rv_cyc = cyc;
    endtask

    task automatic consume();
        bus.result_ready = 1'b1;
        @(posedge clock); #1;
        bus.result_ready = 1'b0;
        check_eq("consume/result_valid", 64'(bus.result_valid), 64'd0);
        check_eq("consume/busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic job_checks(input string tag, input logic [31:0] r, input int rv_cyc);
        int n;
        check_eq($sformatf("%s/result", tag), 64'(r), 64'(ref_password()));
        check_eq($sformatf("%s/instr_count", tag), 64'(bus.instr_count), 64'(jc.size()));
        check_eq($sformatf("%s/steps", tag), 64'(steps_seen), 64'(jc.size()));
        n = (issued.size() < jc.size()) ? issued.size() : jc.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s/order[%0d]", tag, i), 64'(issued[i]), 64'({jd[i], jc[i]}));
        end
        check_eq($sformatf("%s/accept_to_step", tag), 64'(first_step_cyc - accept_cyc), 64'd2);
        check_eq($sformatf("%s/drain_len", tag), 64'(rv_cyc - last_step_cyc), 64'(LAT + 1));
    endtask

    task automatic run_full(input string tag, input int gap, input bit do_consume,
                            output logic [31:0] r);
        bit ab;
        int rv_cyc;
        pulse_start();
        stream(gap, -1, ab);
        wait_result(r, rv_cyc);
        job_checks(tag, r, rv_cyc);
        $display("job %s: n=%0d gap=%0d result=%0d expected=%0d", tag, jc.size(), gap, r, ref_password());
        if (do_consume) consume();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq($sformatf("%s/in_ready", tag), 64'(bus.in_ready), 64'd0);
        check_eq($sformatf("%s/dp_clear", tag), 64'(bus.dp_clear), 64'd0);
        check_eq($sformatf("%s/dp_step", tag), 64'(bus.dp_step), 64'd0);
        check_eq($sformatf("%s/busy", tag), 64'(bus.busy), 64'd0);
        check_eq($sformatf("%s/result_valid", tag), 64'(bus.result_valid), 64'd0);
        check_eq($sformatf("%s/result", tag), 64'(bus.result), 64'd0);
        check_eq($sformatf("%s/instr_count", tag), 64'(bus.instr_count), 64'd0);
        check_eq($sformatf("%s/dp_clicks", tag), 64'(bus.dp_clicks), 64'd0);
        check_eq($sformatf("%s/dp_direction", tag), 64'(bus.dp_direction), 64'(LEFT));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        bit          ab;
        int          rv_cyc;
        int          s0;

        bus.start        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_dir       = LEFT;
        bus.in_clicks    = '0;
        bus.in_last      = 1'b0;
        bus.result_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Reference sequence, back to back and with gaps.
        load_aoc();
        run_full("aoc_b2b", 0, 1'b1, r);
        check_eq("aoc_b2b/password3", 64'(r), 64'd3);
        run_full("aoc_gap3", 3, 1'b1, r);
        check_eq("aoc_gap3/password3", 64'(r), 64'd3);

        // Six instructions offered with in_valid held high.
        make_random_job(6);
        run_full("held6", 0, 1'b1, r);

        // Result held in DONE, then restarted without result_ready.
        load_aoc();
        run_full("aoc_hold", 0, 1'b0, r);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check_eq($sformatf("hold%0d/result_valid", k), 64'(bus.result_valid), 64'd1);
            check_eq($sformatf("hold%0d/result", k), 64'(bus.result), 64'd3);
        end
        pulse_start();
        check_eq("restart/dp_clear", 64'(bus.dp_clear), 64'd1);
        check_eq("restart/result_valid", 64'(bus.result_valid), 64'd0);
        check_eq("restart/busy", 64'(bus.busy), 64'd1);
        @(posedge clock); #1;
        check_eq("restart/dp_clear_one_cycle", 64'(bus.dp_clear), 64'd0);
        make_random_job(5);
        stream(1, -1, ab);
        wait_result(r, rv_cyc);
        job_checks("restart_job", r, rv_cyc);
        $display("job restart_job: n=%0d result=%0d expected=%0d", jc.size(), r, ref_password());
        consume();

        // Reset after the third issued instruction.
        load_aoc();
        pulse_start();
        stream(0, 3, ab);
        check_eq("abort/reached_third_step", 64'(ab), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("midjob_reset");
        s0    = steps_seen;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check_eq($sformatf("post_reset%0d/dp_step", k), 64'(bus.dp_step), 64'd0);
            check_eq($sformatf("post_reset%0d/result_valid", k), 64'(bus.result_valid), 64'd0);
        end
        check_eq("post_reset/no_steps", 64'(steps_seen), 64'(s0));
        $display("job aborted: steps before reset=%0d", s0);
        run_full("aoc_rerun", 0, 1'b1, r);
        check_eq("aoc_rerun/password3", 64'(r), 64'd3);

        // Single zero-click instruction.
        jd.delete();
        jc.delete();
        jd.push_back(1'b1);
        jc.push_back(32'd0);
        run_full("r0_single", 0, 1'b1, r);

        // Random jobs with random gaps.
        for (int j = 0; j < 6; j++) begin
            make_random_job($urandom_range(1, 12));
            run_full($sformatf("rand%0d", j), $urandom_range(0, 3), 1'b1, r);
        end

        check_eq("clear_step_overlap", 64'(overlap_seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/day1_seq.md
DAY1_SEQ -- requirements
Module: day1_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-002 Parameter DP_LATENCY, default 1, cycles from the last dp_step until dp_password is final.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a job; honoured only in IDLE or DONE.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  instruction accepted when in_valid && in_ready.
REQ-008 in_dir  input  rotDir_t  rotation direction (LEFT/RIGHT).
REQ-009 in_clicks  input  32  rotation magnitude, unsigned.
REQ-010 in_last  input  1  marks the final instruction of the job.
REQ-011 dp_clear  output  1  one-cycle synchronous clear to the dial datapath.
REQ-012 dp_step  output  1  qualifies dp_direction/dp_clicks; the datapath advances only when high.
REQ-013 dp_direction  output  rotDir_t  direction issued to the datapath.
REQ-014 dp_clicks  output  32  clicks issued to the datapath.
REQ-015 dp_password  input  32  running password from the datapath.
REQ-016 busy  output  1  high in CLEAR, RUN, DRAIN.
REQ-017 result_valid  output  1  result available; held until result_ready.
REQ-018 result_ready  input  1  consumer accepts the result.
REQ-019 result  output  32  captured final password.
REQ-020 instr_count  output  32  instructions issued in the current job; saturates at 32'hFFFF_FFFF.

Function
REQ-021 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-022 IDLE --start--> CLEAR; DONE --start--> CLEAR (drops result_valid, even without result_ready); start in any other state is ignored.
REQ-023 CLEAR lasts exactly one cycle, asserts dp_clear=1, zeroes instr_count and the FIFO, then goes to RUN.
REQ-024 in_ready = (state in {CLEAR, RUN}) && FIFO not full && last-not-yet-accepted; there is no bypass, so a full FIFO deasserts in_ready even if a pop occurs that cycle.
REQ-025 After accepting an instruction with in_last=1, in_ready stays 0 until the next job.
REQ-026 In RUN, when the FIFO is non-empty, the head is popped and issued: dp_step=1 with registered dp_direction/dp_clicks one cycle after the pop decision; at most one issue per cycle.
REQ-027 With an empty FIFO in RUN, dp_step=0 (bubble); dp_direction/dp_clicks hold their previous values.
REQ-028 Push and pop in the same cycle SHALL both occur and leave the occupancy unchanged.
REQ-029 Minimum latency from accept (in_valid&&in_ready) to dp_step is 2 cycles with an empty FIFO.
REQ-030 instr_count increments by 1 on each dp_step cycle.
REQ-031 Once the in_last instruction has been issued, RUN -> DRAIN; DRAIN waits DP_LATENCY cycles, then captures dp_password into result and -> DONE.
REQ-032 In DONE, result_valid=1; result_valid && result_ready -> IDLE with result_valid=0 the next cycle.
REQ-033 in_clicks=0 is a legal instruction and is issued normally.
REQ-034 dp_clear and dp_step are never high in the same cycle.

Reset
REQ-035 On reset the FSM goes to IDLE and the FIFO empties; in_ready, dp_clear, dp_step, busy and result_valid are 0; result, instr_count, dp_clicks are 0; dp_direction is LEFT.
REQ-036 Reset asserted mid-job aborts the job with no dp_step after the reset edge and no result.

Structure
REQ-037 rotDir_t (LEFT, RIGHT) SHALL remain in the shared AoC package; the day1_seq state enum SHALL be added to it.
REQ-038 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and depth, with push/pop/full/empty.

Verification
REQ-039 Sequence L68 L30 R48 L5 R60 L55 L1 L99 R14 L82 (last on L82), streamed back-to-back against day1 with dp_step gating -> result=3, instr_count=10.
REQ-040 Hold in_valid=1 for 6 instructions while the datapath path is stalled by the 2-cycle pipeline -> in_ready drops at 4 queued, no instruction is lost or duplicated, and the issue order matches the input order.
REQ-041 in_valid gaps of 3 cycles between instructions -> dp_step bubbles, only 1 step per instruction, result unchanged versus the back-to-back run.
REQ-042 Reset pulsed after the 3rd dp_step of the REQ-039 job -> outputs match REQ-035 the next cycle; a fresh start rerun gives result=3.
REQ-043 result_ready held 0 for 5 cycles in DONE -> result_valid and result are stable; start in DONE -> CLEAR, with dp_clear=1 for one cycle.
REQ-044 Single instruction R0 with in_last -> exactly one dp_step, instr_count=1, DRAIN lasts DP_LATENCY cycles.
